// File: rtl/max_stream_sequencer_pkg.sv
// Shared types and helpers for the max_stream_sequencer block.
//   state_t      : sequencer FSM states (FILL, REDUCE, OUTPUT), 2-bit encoded
//   count_width  : width of the batch fill counter for a given buffer depth
//   COUNT_OUT_W  : width of the optional per-stream element counter
package max_stream_seq_pkg;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    REDUCE = 2'd1,
    OUTPUT = 2'd2
  } state_t;

  localparam int COUNT_OUT_W = 32;

  // Enough bits to hold 0..len inclusive.
  function automatic int count_width(input int len);
    return $clog2(len + 1);
  endfunction

endpackage

// File: rtl/max_stream_sequencer_if.sv
// Stream bundle for max_stream_sequencer.
//   in_valid/in_ready/in_data/in_last : element input stream
//   out_valid/out_ready/out_max       : per-stream result stream
//   out_count (MAX_STREAM_SEQ_COUNT_EN only) : elements accepted in the stream
// Modports: master = producer/consumer side, slave = the sequencer.
interface max_stream_sequencer_if #(
  parameter int BITS = 8
);
  import max_stream_seq_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [BITS-1:0] in_data;
  logic            in_last;
  logic            out_valid;
  logic            out_ready;
  logic [BITS-1:0] out_max;
`ifdef MAX_STREAM_SEQ_COUNT_EN
  logic [COUNT_OUT_W-1:0] out_count;
`endif

  modport master (
    output in_valid, in_data, in_last, out_ready,
    input  in_ready, out_valid, out_max
`ifdef MAX_STREAM_SEQ_COUNT_EN
    , input out_count
`endif
  );

  modport slave (
    input  in_valid, in_data, in_last, out_ready,
    output in_ready, out_valid, out_max
`ifdef MAX_STREAM_SEQ_COUNT_EN
    , output out_count
`endif
  );

endinterface

// File: rtl/max_stream_sequencer_tree_max.sv
// TreeMax: combinational unsigned maximum over LEN packed leaves.
//   leaves  : LEN elements of BITS each, element i at [i*BITS +: BITS]
//   max_val : largest leaf
// Built by recursively splitting the leaves in halves, giving a balanced
// comparator tree of depth ceil(log2(LEN)).
module max_stream_sequencer_tree_max #(
  parameter int BITS = 8,
  parameter int LEN  = 16
) (
  input  logic [LEN*BITS-1:0] leaves,
  output logic [BITS-1:0]     max_val
);

  generate
    if (LEN == 1) begin : g_leaf
      assign max_val = leaves;
    end else begin : g_node
      localparam int LO = LEN / 2;
      localparam int HI = LEN - LO;
      logic [BITS-1:0] max_lo;
      logic [BITS-1:0] max_hi;

      max_stream_sequencer_tree_max #(.BITS(BITS), .LEN(LO)) u_lo (
        .leaves (leaves[LO*BITS-1:0]),
        .max_val(max_lo)
      );

      max_stream_sequencer_tree_max #(.BITS(BITS), .LEN(HI)) u_hi (
        .leaves (leaves[LEN*BITS-1:LO*BITS]),
        .max_val(max_hi)
      );

      assign max_val = (max_lo > max_hi) ? max_lo : max_hi;
    end
  endgenerate

endmodule

// File: rtl/max_stream_sequencer.sv
// max_stream_sequencer: gathers unsigned elements into a LEN-deep batch
// buffer, reduces each batch through one TreeMax, folds it into a running
// maximum and emits one result per in_last-terminated stream.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : max_stream_sequencer_if.slave (input stream, result stream)
// Optional: define MAX_STREAM_SEQ_COUNT_EN to add bus.out_count, the
// saturating number of elements accepted in the reported stream.
module max_stream_sequencer
  import max_stream_seq_pkg::*;
#(
  parameter int BITS = 8,
  parameter int LEN  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  max_stream_sequencer_if.slave   bus
);

  localparam int CW = count_width(LEN);

  state_t              state;
  logic [CW-1:0]       count;
  logic [CW-1:0]       count_nxt;
  logic [LEN-1:0]      mask;
  logic                last_seen;
  logic [BITS-1:0]     running;
  logic [BITS-1:0]     out_max_r;
  logic                out_valid_r;
  logic [LEN*BITS-1:0] slot;
  logic [LEN*BITS-1:0] tree_in;
  logic [BITS-1:0]     tree_max;
  logic [BITS-1:0]     red_max;
  logic                accept;

  function automatic logic [BITS-1:0] umax(input logic [BITS-1:0] a,
                                           input logic [BITS-1:0] b);
    return (a > b) ? a : b;
  endfunction

  assign accept    = bus.in_valid && (state == FILL);
  assign count_nxt = count + 1'b1;

  // Slot data needs no reset: the mask decides which slots are live.
  always_ff @(posedge clk) begin
    for (int i = 0; i < LEN; i++) begin
      if (accept && count == CW'(i)) slot[i*BITS +: BITS] <= bus.in_data;
    end
  end

  // Unwritten slots feed 0, the identity for unsigned max.
  always_comb begin
    tree_in = '0;
    for (int i = 0; i < LEN; i++) begin
      if (mask[i]) tree_in[i*BITS +: BITS] = slot[i*BITS +: BITS];
    end
  end

  max_stream_sequencer_tree_max #(.BITS(BITS), .LEN(LEN)) u_tree (
    .leaves (tree_in),
    .max_val(tree_max)
  );

  assign red_max = umax(running, tree_max);

`ifdef MAX_STREAM_SEQ_COUNT_EN
  logic [COUNT_OUT_W-1:0] elem_cnt;

  function automatic logic [COUNT_OUT_W-1:0] sat_inc(input logic [COUNT_OUT_W-1:0] x);
    return (&x) ? x : x + 1'b1;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      elem_cnt <= '0;
    end else if (accept) begin
      elem_cnt <= sat_inc(elem_cnt);
    end else if (state == OUTPUT && bus.out_ready) begin
      elem_cnt <= '0;
    end
  end

  assign bus.out_count = elem_cnt;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= FILL;
      count       <= '0;
      mask        <= '0;
      last_seen   <= 1'b0;
      running     <= '0;
      out_max_r   <= '0;
      out_valid_r <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          if (bus.in_valid) begin
            for (int i = 0; i < LEN; i++) begin
              if (count == CW'(i)) mask[i] <= 1'b1;
            end
            count <= count_nxt;
            if (bus.in_last) last_seen <= 1'b1;
            if (count_nxt == CW'(LEN) || bus.in_last) state <= REDUCE;
          end
        end
        REDUCE: begin
          running <= red_max;
          mask    <= '0;
          count   <= '0;
          if (last_seen) begin
            out_max_r   <= red_max;
            out_valid_r <= 1'b1;
            state       <= OUTPUT;
          end else begin
            state <= FILL;
          end
        end
        OUTPUT: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            running     <= '0;
            last_seen   <= 1'b0;
            state       <= FILL;
          end
        end
        default: state <= FILL;
      endcase
    end
  end

  assign bus.in_ready  = (state == FILL);
  assign bus.out_valid = out_valid_r;
  assign bus.out_max   = out_max_r;

endmodule

// File: tb/tb_max_stream_sequencer.sv
// Directed testbench for max_stream_sequencer with LEN=4, BITS=8.
// Covers reset values, full and multi-batch streams, back-pressure on the
// result, all-zero streams, stale-slot masking and asynchronous reset.
module tb_max_stream_sequencer;

  localparam int BITS = 8;
  localparam int LEN  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  int checks = 0;
  int errors = 0;

  max_stream_sequencer_if #(.BITS(BITS)) bus ();

  max_stream_sequencer #(.BITS(BITS), .LEN(LEN)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Present one element; waits (bounded) for in_ready, returns 1ns after the
  // accepting edge.
  task automatic send(input logic [7:0] d, input logic last);
    int n = 0;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 50) check("in_ready_timeout", 32'd0, 32'd1);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_last  = last;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    bus.in_data  = '0;
  endtask

  // Called 1ns after the edge accepting the last element: checks the REDUCE
  // cycle, then the result one edge later.
  task automatic expect_result(input string tag, input logic [7:0] exp, input int exp_cnt);
    check({tag, "_reduce_ready"}, 32'(bus.in_ready), 32'd0);
    check({tag, "_reduce_valid"}, 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1;
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_max"}, 32'(bus.out_max), 32'(exp));
`ifdef MAX_STREAM_SEQ_COUNT_EN
    check({tag, "_count"}, bus.out_count, 32'(exp_cnt));
`else
    if (exp_cnt < 0) check({tag, "_cnt_arg"}, 32'd0, 32'd1);
`endif
  endtask

  // Completes a transfer with out_ready held high and checks return to FILL.
  task automatic finish_transfer(input string tag);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_done_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_done_ready"}, 32'(bus.in_ready), 32'd1);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_max", 32'(bus.out_max), 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Full batch 3,9,2,7 -> 9
    send(8'd3, 1'b0);
    send(8'd9, 1'b0);
    send(8'd2, 1'b0);
    send(8'd7, 1'b1);
    expect_result("full4", 8'd9, 4);
    finish_transfer("full4");

    // Two batches 5,1,8,4 | 6,12,3 -> 12, one bubble after element 4
    send(8'd5, 1'b0);
    send(8'd1, 1'b0);
    send(8'd8, 1'b0);
    send(8'd4, 1'b0);
    check("b2_bubble_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk);
    #1;
    check("b2_bubble_end", 32'(bus.in_ready), 32'd1);
    send(8'd6, 1'b0);
    send(8'd12, 1'b0);
    send(8'd3, 1'b1);
    expect_result("two_batch", 8'd12, 7);
    finish_transfer("two_batch");

    // Single element with result back-pressure
    bus.out_ready = 1'b0;
    send(8'hAB, 1'b1);
    expect_result("single", 8'hAB, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check("hold_valid", 32'(bus.out_valid), 32'd1);
      check("hold_max", 32'(bus.out_max), 32'hAB);
      check("hold_in_ready", 32'(bus.in_ready), 32'd0);
    end
    finish_transfer("single");
    send(8'h01, 1'b1);
    expect_result("after_reset_run", 8'h01, 1);
    finish_transfer("after_reset_run");

    // All zeros across two full batches, last on the 8th element
    for (int i = 0; i < 8; i++) send(8'h00, i == 7);
    expect_result("zeros", 8'h00, 8);
    finish_transfer("zeros");

    send(8'hFF, 1'b0);
    send(8'h00, 1'b0);
    send(8'h00, 1'b1);
    expect_result("ff00", 8'hFF, 3);
    finish_transfer("ff00");

    // Slot 3 holds stale 0x80 afterwards; a 2-element stream must ignore it
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    send(8'h03, 1'b0);
    send(8'h80, 1'b1);
    expect_result("stale_fill", 8'h80, 4);
    finish_transfer("stale_fill");
    send(8'h05, 1'b0);
    send(8'h06, 1'b1);
    expect_result("stale_mask", 8'h06, 2);
    finish_transfer("stale_mask");

    // Asynchronous reset while a result is pending
    bus.out_ready = 1'b0;
    send(8'h40, 1'b1);
    expect_result("pre_rst", 8'h40, 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(bus.out_valid), 32'd0);
    check("async_rst_ready", 32'(bus.in_ready), 32'd1);
    check("async_rst_max", 32'(bus.out_max), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    send(8'h10, 1'b1);
    expect_result("post_rst", 8'h10, 1);
    finish_transfer("post_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time guard so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
